// File: rtl/conv_pkg.sv
// Shared definitions for the conv datapath: weight memory widths
// and the fetch sequencer state encoding.
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with synchronous active-high reset.
// Ports: i_push/i_data write side, i_pop read side, o_data is the head
// (zero when empty), o_empty/o_full/o_count report occupancy.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_pop,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Empty head reads as zero so the output is clean after reset.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: bursts sequential reads from the weight SRAM,
// absorbs its 1-cycle read latency in a return FIFO and streams words out.
// Ports: start/base_addr/num_words command, busy/done status,
// mem_read_* SRAM read port, m_weight_* valid/ready output stream.
module weight_fetch_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_req,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  m_weight_valid,
  output logic [DATA_WIDTH-1:0] m_weight_data,
  input  logic                  m_weight_ready
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [FAW+1:0] DEPTH_W = (FAW+2)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr_ptr;
  logic [CNT_WIDTH-1:0]  r_issue_left;
  logic [CNT_WIDTH-1:0]  r_out_left;
  logic                  r_inflight;

  logic [FAW:0]          w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic [FAW+1:0]        w_occ;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_done;

  // Buffered words plus the one in flight must leave a free slot,
  // otherwise the returning word would have nowhere to land.
  assign w_occ   = {1'b0, w_fifo_count} + (FAW+2)'(r_inflight);
  assign w_issue = (r_state == ST_FETCH)
                && (r_issue_left != '0)
                && !w_fifo_full
                && (w_occ < DEPTH_W);

  assign w_pop  = !w_fifo_empty && m_weight_ready;
  assign w_done = (r_state == ST_DRAIN) && (r_out_left == '0);

  assign busy           = (r_state != ST_IDLE);
  assign done           = w_done;
  assign mem_read_req   = w_issue;
  assign mem_read_addr  = r_addr_ptr;
  assign m_weight_valid = !w_fifo_empty;
  assign m_weight_data  = w_fifo_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr_ptr   <= '0;
      r_issue_left <= '0;
      r_out_left   <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr_ptr   <= base_addr;
            r_issue_left <= num_words;
            r_out_left   <= num_words;
            r_state      <= (num_words == '0) ? ST_DRAIN : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_issue) begin
            r_addr_ptr   <= r_addr_ptr + ADDR_ONE;
            r_issue_left <= r_issue_left - CNT_ONE;
            if (r_issue_left == CNT_ONE) begin
              r_state <= ST_DRAIN;
            end
          end
          // Words already stream out while the burst is still issuing.
          if (w_pop) begin
            r_out_left <= r_out_left - CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (w_done) begin
            r_state <= ST_IDLE;
          end else if (w_pop) begin
            r_out_left <= r_out_left - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Clearing r_inflight on reset drops the word of a read issued
  // in the reset cycle.
  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_ret_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  (mem_read_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

endmodule
